// File: rtl/temp_ctrl_pkg.sv
// Shared types, widths and helpers for the temperature readout path.
package temp_ctrl_pkg;

    localparam int TEMP_W   = 8;
    localparam int BCD_W    = 4;
    localparam int BCD_ITER = 8;
    // Double-dabble working register: {tens, units, binary}
    localparam int DD_W     = 2 * BCD_W + TEMP_W;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_TICK = 3'd1,
        START     = 3'd2,
        WAIT_DONE = 3'd3,
        CONVERT   = 3'd4,
        LOAD      = 3'd5
    } state_e;

    // Saturate a reading to the displayable ceiling.
    function automatic logic [TEMP_W-1:0] clamp_temp(input logic [TEMP_W-1:0] v,
                                                     input logic [TEMP_W-1:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    // One double-dabble iteration: add 3 to any digit >= 5, then shift left.
    function automatic logic [DD_W-1:0] dabble_step(input logic [DD_W-1:0] s);
        logic [DD_W-1:0] a;
        a = s;
        if (a[DD_W-1 -: BCD_W] >= 4'd5) begin
            a[DD_W-1 -: BCD_W] = a[DD_W-1 -: BCD_W] + 4'd3;
        end else begin
            a[DD_W-1 -: BCD_W] = a[DD_W-1 -: BCD_W];
        end
        if (a[TEMP_W +: BCD_W] >= 4'd5) begin
            a[TEMP_W +: BCD_W] = a[TEMP_W +: BCD_W] + 4'd3;
        end else begin
            a[TEMP_W +: BCD_W] = a[TEMP_W +: BCD_W];
        end
        return {a[DD_W-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/temp_display_ctrl_bin2bcd_seq.sv
// Iterative 8-bit to two-digit BCD converter. The first iteration runs on the
// start edge, so the result and done pulse appear exactly BCD_ITER clocks
// after start. Inputs must already be limited to 0..99.
module bin2bcd_seq
    import temp_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [TEMP_W-1:0] bin_i,
    output logic              done_o,
    output logic [BCD_W-1:0]  tens_o,
    output logic [BCD_W-1:0]  units_o
);

    localparam int IT_W = $clog2(BCD_ITER + 1);

    logic [DD_W-1:0] sreg_q;
    logic [DD_W-1:0] sreg_d;
    logic [DD_W-1:0] step_in_s;
    logic [IT_W-1:0] iter_q;
    logic            active_q;
    logic            done_q;

    // Select the fresh operand on start, otherwise continue the running shift.
    always_comb begin
        step_in_s = start_i ? {{(2*BCD_W){1'b0}}, bin_i} : sreg_q;
        sreg_d    = dabble_step(step_in_s);
    end

    // Iteration counter, shift register and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q   <= '0;
            iter_q   <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else if (start_i) begin
            sreg_q   <= sreg_d;
            iter_q   <= IT_W'(1);
            active_q <= 1'b1;
            done_q   <= 1'b0;
        end else if (active_q) begin
            sreg_q <= sreg_d;
            iter_q <= iter_q + IT_W'(1);
            if (iter_q == IT_W'(BCD_ITER - 1)) begin
                active_q <= 1'b0;
                done_q   <= 1'b1;
            end else begin
                active_q <= 1'b1;
                done_q   <= 1'b0;
            end
        end else begin
            done_q <= 1'b0;
        end
    end

    assign done_o  = done_q;
    assign tens_o  = sreg_q[DD_W-1 -: BCD_W];
    assign units_o = sreg_q[TEMP_W +: BCD_W];

endmodule

// File: rtl/temp_display_ctrl.sv
// Periodic sensor sampling sequencer feeding the 7-segment display driver:
// trigger conversion, wait with timeout, clamp, convert to BCD, pulse load.
module temp_display_ctrl
    import temp_ctrl_pkg::*;
#(
    parameter int SAMPLE_DIV = 1000,
    parameter int TIMEOUT    = 255,
    parameter int TEMP_MAX   = 99
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic              conv_start,
    input  logic              conv_done,
    input  logic [TEMP_W-1:0] conv_data,
    output logic [TEMP_W-1:0] temp_out,
    output logic [BCD_W-1:0]  bcd_tens,
    output logic [BCD_W-1:0]  bcd_units,
    output logic              load,
    output logic              over_range,
    output logic              timeout_err,
    output logic              busy
);

    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [DIV_W-1:0]  DIV_RELOAD = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [TMO_W-1:0]  TMO_LOAD   = TMO_W'(TIMEOUT);
    localparam logic [TEMP_W-1:0] TEMP_LIM   = TEMP_W'(TEMP_MAX);

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_q;
    logic [TMO_W-1:0]   tmo_q;
    logic               tick_s;
    logic               done_hit_s;
    logic               expire_s;
    logic [TEMP_W-1:0]  clamped_s;
    logic               cap_ovr_q;
    logic [TEMP_W-1:0]  cap_temp_q;
    logic               b2b_done_s;
    logic [BCD_W-1:0]   b2b_tens_s;
    logic [BCD_W-1:0]   b2b_units_s;
    logic               conv_start_d, load_d, busy_d;
    logic               conv_start_q, load_q, busy_q;
    logic [TEMP_W-1:0]  temp_out_q;
    logic [BCD_W-1:0]   tens_q, units_q;
    logic               over_range_q, timeout_err_q;

    assign tick_s     = enable && (div_q == '0);
    assign done_hit_s = (state_q == WAIT_DONE) && conv_done;
    // conv_done takes priority over expiry in the same cycle
    assign expire_s   = (state_q == WAIT_DONE) && !conv_done && (tmo_q == TMO_W'(1));
    assign clamped_s  = clamp_temp(conv_data, TEMP_LIM);

    bin2bcd_seq u_bin2bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (done_hit_s),
        .bin_i   (clamped_s),
        .done_o  (b2b_done_s),
        .tens_o  (b2b_tens_s),
        .units_o (b2b_units_s)
    );

    // Sample period divider: counts only while enabled, tick reloads it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else if (!enable || (div_q == '0)) begin
            div_q <= DIV_RELOAD;
        end else begin
            div_q <= div_q - DIV_W'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; ticks outside WAIT_TICK are simply dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = enable ? WAIT_TICK : IDLE;
            WAIT_TICK: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (tick_s) begin
                    state_d = START;
                end else begin
                    state_d = WAIT_TICK;
                end
            end
            START:     state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (conv_done) begin
                    state_d = CONVERT;
                end else if (expire_s) begin
                    state_d = WAIT_TICK;
                end else begin
                    state_d = WAIT_DONE;
                end
            end
            CONVERT:   state_d = b2b_done_s ? LOAD : CONVERT;
            LOAD:      state_d = enable ? WAIT_TICK : IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // FSM output decode from the next state so the registered pulses align with the state.
    always_comb begin
        conv_start_d = (state_d == START);
        load_d       = (state_d == LOAD);
        busy_d       = (state_d == START) || (state_d == WAIT_DONE) ||
                       (state_d == CONVERT) || (state_d == LOAD);
    end

    // Registered control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conv_start_q <= 1'b0;
            load_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            conv_start_q <= conv_start_d;
            load_q       <= load_d;
            busy_q       <= busy_d;
        end
    end

    // Timeout counter: loaded leaving START, counts down through WAIT_DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else if (state_q == START) begin
            tmo_q <= TMO_LOAD;
        end else if (state_q == WAIT_DONE) begin
            tmo_q <= tmo_q - TMO_W'(1);
        end else begin
            tmo_q <= tmo_q;
        end
    end

    // Capture the clamped sample and its pending over-range flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_temp_q <= '0;
            cap_ovr_q  <= 1'b0;
        end else if (done_hit_s) begin
            cap_temp_q <= clamped_s;
            cap_ovr_q  <= (conv_data > TEMP_LIM);
        end else begin
            cap_temp_q <= cap_temp_q;
            cap_ovr_q  <= cap_ovr_q;
        end
    end

    // Display outputs change only on entry to LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            temp_out_q   <= '0;
            tens_q       <= '0;
            units_q      <= '0;
            over_range_q <= 1'b0;
        end else if ((state_q == CONVERT) && b2b_done_s) begin
            temp_out_q   <= cap_temp_q;
            tens_q       <= b2b_tens_s;
            units_q      <= b2b_units_s;
            over_range_q <= cap_ovr_q;
        end else begin
            temp_out_q   <= temp_out_q;
            tens_q       <= tens_q;
            units_q      <= units_q;
            over_range_q <= over_range_q;
        end
    end

    // Sticky timeout flag, cleared as the next reading is loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err_q <= 1'b0;
        end else if (expire_s) begin
            timeout_err_q <= 1'b1;
        end else if (state_d == LOAD) begin
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= timeout_err_q;
        end
    end

    assign conv_start  = conv_start_q;
    assign load        = load_q;
    assign busy        = busy_q;
    assign temp_out    = temp_out_q;
    assign bcd_tens    = tens_q;
    assign bcd_units   = units_q;
    assign over_range  = over_range_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_temp_display_ctrl.sv
// Self-checking bench for temp_display_ctrl with SAMPLE_DIV=100, TIMEOUT=20.
module tb_temp_display_ctrl;

    localparam int SAMPLE_DIV = 100;
    localparam int TIMEOUT    = 20;
    localparam int TEMP_MAX   = 99;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       conv_done = 1'b0;
    logic [7:0] conv_data = 8'd0;
    logic       conv_start, load, over_range, timeout_err, busy;
    logic [7:0] temp_out;
    logic [3:0] bcd_tens, bcd_units;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int prev_start = -1;
    // Reference display state
    int exp_temp = 0, exp_tens = 0, exp_units = 0, exp_ovr = 0, exp_terr = 0;

    temp_display_ctrl #(
        .SAMPLE_DIV (SAMPLE_DIV),
        .TIMEOUT    (TIMEOUT),
        .TEMP_MAX   (TEMP_MAX)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .conv_start  (conv_start),
        .conv_done   (conv_done),
        .conv_data   (conv_data),
        .temp_out    (temp_out),
        .bcd_tens    (bcd_tens),
        .bcd_units   (bcd_units),
        .load        (load),
        .over_range  (over_range),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_display(input string tag);
        chk({tag, "_temp"},  32'(temp_out),   exp_temp);
        chk({tag, "_tens"},  32'(bcd_tens),   exp_tens);
        chk({tag, "_units"}, 32'(bcd_units),  exp_units);
        chk({tag, "_ovr"},   32'(over_range), exp_ovr);
    endtask

    task automatic wait_start(output bit found, output int t);
        found = 1'b0;
        t = -1;
        for (int i = 0; i < 2 * SAMPLE_DIV + 10; i++) begin
            if (conv_start) begin
                found = 1'b1;
                t = cyc;
                break;
            end
            step();
        end
    endtask

    // One sampling period: sensor answers d cycles after conv_start (0 = never).
    task automatic do_conv(input int d, input int v, input bit drop_en);
        bit found;
        int t, load_cyc, terr_cyc, nloads, nt;
        bit accept;
        wait_start(found, t);
        chk("start_seen", 32'(found), 1);
        if (!found) return;
        chk("busy_at_start", 32'(busy), 1);
        if (prev_start >= 0) chk("start_period", t - prev_start, SAMPLE_DIV);
        prev_start = t;
        accept = (d >= 1) && (d <= TIMEOUT);
        nt = (v > TEMP_MAX) ? TEMP_MAX : v;
        load_cyc = -1;
        terr_cyc = -1;
        nloads = 0;
        for (int k = 1; k <= 35; k++) begin
            step();
            if (drop_en && k == 1) enable = 1'b0;
            conv_done = (k == d);
            conv_data = (k == d) ? 8'(v) : 8'($urandom);
            if (load) begin
                nloads++;
                if (load_cyc < 0) begin
                    load_cyc = cyc;
                    chk("load_temp",  32'(temp_out),   nt);
                    chk("load_tens",  32'(bcd_tens),   nt / 10);
                    chk("load_units", 32'(bcd_units),  nt % 10);
                    chk("load_ovr",   32'(over_range), (v > TEMP_MAX) ? 1 : 0);
                end
            end
            if (load_cyc >= 0 && cyc == load_cyc + 1) chk("terr_after_load", 32'(timeout_err), 0);
            if (timeout_err && terr_cyc < 0 && exp_terr == 0) terr_cyc = cyc;
        end
        conv_done = 1'b0;
        if (accept) begin
            chk("load_count", nloads, 1);
            chk("load_cycle", load_cyc, t + d + 9);
            if (exp_terr == 0) chk("terr_no_rise", terr_cyc, -1);
            exp_temp = nt;
            exp_tens = nt / 10;
            exp_units = nt % 10;
            exp_ovr = (v > TEMP_MAX) ? 1 : 0;
            exp_terr = 0;
        end else begin
            chk("load_count_tmo", nloads, 0);
            if (exp_terr == 0) chk("terr_cycle", terr_cyc, t + TIMEOUT + 1);
            chk("terr_sticky", 32'(timeout_err), 1);
            check_display("tmo_hold");
            exp_terr = 1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        int t, n, r, d, v;

        // Reset state
        rst_n = 1'b0;
        step(); step(); step();
        chk("rst_start", 32'(conv_start), 0);
        chk("rst_load",  32'(load), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_terr",  32'(timeout_err), 0);
        check_display("rst");
        rst_n = 1'b1;
        step();
        enable = 1'b1;

        // Directed: nominal, boundaries, timeout, recovery, simultaneous, late answer
        do_conv(3, 37, 1'b0);
        do_conv(5, 0, 1'b0);
        do_conv(7, 99, 1'b0);
        do_conv(2, 100, 1'b0);
        do_conv(9, 255, 1'b0);
        do_conv(0, 0, 1'b0);
        do_conv(4, 42, 1'b0);
        do_conv(TIMEOUT, 55, 1'b0);
        do_conv(TIMEOUT + 3, 66, 1'b0);
        do_conv(1, 12, 1'b0);

        // Randomized sampling periods
        for (int i = 0; i < 14; i++) begin
            r = $urandom_range(0, 9);
            d = (r < 8) ? $urandom_range(1, TIMEOUT) : $urandom_range(TIMEOUT + 1, 25);
            r = $urandom_range(0, 7);
            case (r)
                0: v = 0;
                1: v = 99;
                2: v = 100;
                3: v = 255;
                default: v = $urandom_range(0, 255);
            endcase
            do_conv(d, v, 1'b0);
        end

        // enable dropped during WAIT_DONE: load still happens, then silence
        do_conv(6, 81, 1'b1);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (conv_start) n++;
        end
        chk("no_start_idle", n, 0);
        chk("idle_busy", 32'(busy), 0);
        enable = 1'b1;
        prev_start = -1;

        // Reset asserted during CONVERT
        wait_start(found, t);
        chk("start_seen_rst", 32'(found), 1);
        for (int k = 1; k <= 6; k++) begin
            step();
            conv_done = (k == 2);
            conv_data = 8'd77;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 1'b0);
        chk("arst_load", 32'(load), 0);
        chk("arst_start", 32'(conv_start), 0);
        chk("arst_terr", 32'(timeout_err), 0);
        exp_temp = 0; exp_tens = 0; exp_units = 0; exp_ovr = 0; exp_terr = 0;
        check_display("arst");
        n = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (load) n++;
        end
        rst_n = 1'b1;
        enable = 1'b0;
        step();
        conv_done = 1'b1;
        conv_data = 8'd88;
        step();
        conv_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (load || conv_start) n++;
        end
        chk("no_load_after_rst", n, 0);
        chk("spurious_busy", 32'(busy), 0);
        check_display("spurious");
        prev_start = -1;
        enable = 1'b1;
        do_conv(4, 63, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
